// File: rtl/codebreaker_pkg.sv
// Shared types, ASCII bounds and the printable-byte test for the key search.
package codebreaker_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StCheck,
    StDisplay,
    StFound,
    StNotFound
  } state_e;

  localparam logic [7:0] AsciiUpperA = 8'h41;
  localparam logic [7:0] AsciiUpperZ = 8'h5A;
  localparam logic [7:0] AsciiDigit0 = 8'h30;
  localparam logic [7:0] AsciiDigit9 = 8'h39;
  localparam logic [7:0] AsciiSpace  = 8'h20;

  // True for A-Z, 0-9 or space.
  function automatic logic is_printable(input logic [7:0] b);
    return ((b >= AsciiUpperA) && (b <= AsciiUpperZ)) ||
           ((b >= AsciiDigit0) && (b <= AsciiDigit9)) ||
           (b == AsciiSpace);
  endfunction

endpackage

// File: rtl/ascii_check16.sv
// Passes when every byte of a 16-byte block is printable.
module ascii_check16
  import codebreaker_pkg::*;
(
  input  logic [127:0] data_i,
  output logic         pass_o
);

  // AND-reduce the per-byte printable test.
  always_comb begin
    pass_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!is_printable(data_i[8*i +: 8])) begin
        pass_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/decrypt_rc4.sv
// Stand-in decrypt engine: done after 4 enabled cycles, output is a byte-wise XOR with key[7:0].
module decrypt_rc4 (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [23:0]  key,
  input  logic [127:0] bytes_in,
  output logic [127:0] bytes_out,
  output logic         done
);

  logic [2:0] cnt_q, cnt_d;
  logic       unused_key_hi;

  assign unused_key_hi = ^key[23:8];

  // Count enabled cycles, saturate at 4, clear whenever enable drops.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = 3'd0;
    end else if (cnt_q != 3'd4) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done      = (cnt_q == 3'd4);
  assign bytes_out = bytes_in ^ {16{key[7:0]}};

endmodule

// File: rtl/codebreaker_multi.sv
// Brute-force key search with NUM_ENG parallel decrypt engines checked for printable output.
module codebreaker_multi
  import codebreaker_pkg::*;
#(
  parameter int unsigned NUM_ENG = 2,
  parameter int unsigned KEY_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [127:0]     cyphertext,
  input  logic [KEY_W-1:0] key_limit,
  output logic [15:0]      key_display,
  output logic             stopwatch_run,
  output logic             draw_plaintext,
  input  logic             done_drawing_plaintext,
  output logic [127:0]     plaintext_to_draw,
  output logic             found,
  output logic             not_found,
  output logic [KEY_W-1:0] found_key
);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   base_key_q, base_key_d;
  logic [KEY_W-1:0]   found_key_q, found_key_d;
  logic [KEY_W-1:0]   limit_q, limit_d;
  logic [127:0]       ct_q, ct_d;
  logic [127:0]       pt_q, pt_d;

  logic               eng_en;
  logic [KEY_W:0]     eng_sum  [NUM_ENG];
  logic [23:0]        eng_key  [NUM_ENG];
  logic [127:0]       eng_out  [NUM_ENG];
  logic [NUM_ENG-1:0] eng_done;
  logic [NUM_ENG-1:0] eng_pass;
  logic [NUM_ENG-1:0] cand;

  logic               win_valid;
  logic [127:0]       win_pt;
  logic [KEY_W-1:0]   win_key;
  logic [KEY_W:0]     next_sum;

  assign eng_en = (state_q == StSearch);

  // One engine plus printable checker per lane; lane keys carry an extra bit so the
  // last batch can't alias back to low keys when compared against the limit.
  for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng
    assign eng_sum[g] = {1'b0, base_key_q} + (KEY_W+1)'(g);
    assign eng_key[g] = 24'(eng_sum[g][KEY_W-1:0]);
    assign cand[g]    = eng_pass[g] && (eng_sum[g] <= {1'b0, limit_q});

    decrypt_rc4 u_eng (
      .clk       (clk),
      .reset     (reset),
      .enable    (eng_en),
      .key       (eng_key[g]),
      .bytes_in  (ct_q),
      .bytes_out (eng_out[g]),
      .done      (eng_done[g])
    );

    ascii_check16 u_chk (
      .data_i (eng_out[g]),
      .pass_o (eng_pass[g])
    );
  end

  // Priority encoder: scan high to low so the lowest-index candidate wins.
  always_comb begin
    win_valid = 1'b0;
    win_pt    = '0;
    win_key   = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_valid = 1'b1;
        win_pt    = eng_out[i];
        win_key   = eng_sum[i][KEY_W-1:0];
      end
    end
  end

  assign next_sum = {1'b0, base_key_q} + (KEY_W+1)'(NUM_ENG);

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    base_key_d  = base_key_q;
    found_key_d = found_key_q;
    limit_d     = limit_q;
    ct_d        = ct_q;
    pt_d        = pt_q;
    case (state_q)
      StIdle, StFound, StNotFound: begin
        if (start) begin
          state_d    = StSearch;
          base_key_d = '0;
          ct_d       = cyphertext;
          limit_d    = key_limit;
        end
      end
      StSearch: begin
        if (&eng_done) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (win_valid) begin
          pt_d        = win_pt;
          found_key_d = win_key;
          state_d     = StDisplay;
        end else if (next_sum[KEY_W] || (next_sum > {1'b0, limit_q})) begin
          state_d = StNotFound;
        end else begin
          base_key_d = next_sum[KEY_W-1:0];
          state_d    = StSearch;
        end
      end
      StDisplay: begin
        if (done_drawing_plaintext) begin
          state_d = StFound;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      base_key_q  <= '0;
      found_key_q <= '0;
      limit_q     <= '0;
      ct_q        <= '0;
      pt_q        <= '0;
    end else begin
      state_q     <= state_d;
      base_key_q  <= base_key_d;
      found_key_q <= found_key_d;
      limit_q     <= limit_d;
      ct_q        <= ct_d;
      pt_q        <= pt_d;
    end
  end

  assign key_display       = base_key_q[KEY_W-1 -: 16];
  assign stopwatch_run     = (state_q == StSearch) || (state_q == StCheck);
  assign draw_plaintext    = (state_q == StDisplay);
  assign found             = (state_q == StFound);
  assign not_found         = (state_q == StNotFound);
  assign plaintext_to_draw = pt_q;
  assign found_key         = found_key_q;

endmodule

// File: tb/tb_codebreaker_multi.sv
// Scoreboard bench for codebreaker_multi across three parameter sets.
module tb_codebreaker_multi;

  typedef struct packed {
    logic         f;
    logic [23:0]  k;
    logic [127:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // dut_a: NUM_ENG=2, KEY_W=24
  logic         start_a = 0, ddp_a = 0;
  logic [127:0] ct_a = '0;
  logic [23:0]  lim_a = '0;
  logic [15:0]  kd_a;
  logic         sw_a, draw_a, fnd_a, nf_a;
  logic [127:0] pt_a;
  logic [23:0]  fk_a;
  // dut_b: NUM_ENG=4, KEY_W=24
  logic         start_b = 0, ddp_b = 0;
  logic [127:0] ct_b = '0;
  logic [23:0]  lim_b = '0;
  logic [15:0]  kd_b;
  logic         sw_b, draw_b, fnd_b, nf_b;
  logic [127:0] pt_b;
  logic [23:0]  fk_b;
  // dut_c: NUM_ENG=8, KEY_W=16
  logic         start_c = 0, ddp_c = 0;
  logic [127:0] ct_c = '0;
  logic [15:0]  lim_c = '0;
  logic [15:0]  kd_c;
  logic         sw_c, draw_c, fnd_c, nf_c;
  logic [127:0] pt_c;
  logic [15:0]  fk_c;

  codebreaker_multi #(.NUM_ENG(2), .KEY_W(24)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cyphertext(ct_a), .key_limit(lim_a),
    .key_display(kd_a), .stopwatch_run(sw_a), .draw_plaintext(draw_a),
    .done_drawing_plaintext(ddp_a), .plaintext_to_draw(pt_a), .found(fnd_a),
    .not_found(nf_a), .found_key(fk_a)
  );
  codebreaker_multi #(.NUM_ENG(4), .KEY_W(24)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cyphertext(ct_b), .key_limit(lim_b),
    .key_display(kd_b), .stopwatch_run(sw_b), .draw_plaintext(draw_b),
    .done_drawing_plaintext(ddp_b), .plaintext_to_draw(pt_b), .found(fnd_b),
    .not_found(nf_b), .found_key(fk_b)
  );
  codebreaker_multi #(.NUM_ENG(8), .KEY_W(16)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .cyphertext(ct_c), .key_limit(lim_c),
    .key_display(kd_c), .stopwatch_run(sw_c), .draw_plaintext(draw_c),
    .done_drawing_plaintext(ddp_c), .plaintext_to_draw(pt_c), .found(fnd_c),
    .not_found(nf_c), .found_key(fk_c)
  );

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  logic [127:0] hw;
  logic         o_sw, o_draw, o_fnd, o_nf;
  logic [15:0]  o_kd;
  logic [23:0]  o_key;
  logic [127:0] o_pt;
  logic [15:0]  prev_kd;
  logic         wrapped;

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic sample(input int sel);
    case (sel)
      0: begin
        o_sw = sw_a; o_draw = draw_a; o_fnd = fnd_a; o_nf = nf_a;
        o_kd = kd_a; o_key = fk_a; o_pt = pt_a;
      end
      1: begin
        o_sw = sw_b; o_draw = draw_b; o_fnd = fnd_b; o_nf = nf_b;
        o_kd = kd_b; o_key = fk_b; o_pt = pt_b;
      end
      default: begin
        o_sw = sw_c; o_draw = draw_c; o_fnd = fnd_c; o_nf = nf_c;
        o_kd = kd_c; o_key = {8'h00, fk_c}; o_pt = pt_c;
      end
    endcase
  endtask

  task automatic set_ddp(input int sel, input logic v);
    case (sel)
      0: ddp_a = v;
      1: ddp_b = v;
      default: ddp_c = v;
    endcase
  endtask

  task automatic set_start(input int sel, input logic v, input logic [127:0] ct,
                           input logic [23:0] lim);
    case (sel)
      0: begin start_a = v; ct_a = ct; lim_a = lim; end
      1: begin start_b = v; ct_b = ct; lim_b = lim; end
      default: begin start_c = v; ct_c = ct; lim_c = lim[15:0]; end
    endcase
  endtask

  task automatic check_zero(input int sel, input string name);
    sample(sel);
    total++;
    if ({o_sw, o_draw, o_fnd, o_nf, o_kd, o_key, o_pt} !== '0) begin
      bad++;
      $display("FAIL %s: sw=%0b draw=%0b found=%0b nf=%0b kd=%h key=%h pt=%h, want all 0",
               name, o_sw, o_draw, o_fnd, o_nf, o_kd, o_key, o_pt);
    end
  endtask

  // Pulse start for one cycle; the search must be running on the next cycle.
  task automatic launch(input int sel, input logic [127:0] ct, input logic [23:0] lim,
                        input exp_t e, input string name);
    exp_q.push_back(e);
    @(negedge clk);
    set_start(sel, 1'b1, ct, lim);
    @(negedge clk);
    set_start(sel, 1'b0, '0, '0);
    sample(sel);
    total++;
    if ({o_sw, o_fnd, o_nf, o_draw} !== 4'b1000) begin
      bad++;
      $display("FAIL %s_launch: sw/found/nf/draw=%b, want 1000", name,
               {o_sw, o_fnd, o_nf, o_draw});
    end
  endtask

  // Wait for the DUT to finish, pop the expected result and compare.
  task automatic collect(input int sel, input int budget, input string name);
    exp_t e;
    logic got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      sample(sel);
      if (sel == 2) begin
        if (o_kd < prev_kd) wrapped = 1'b1;
        prev_kd = o_kd;
      end
      if (o_draw || o_nf || o_fnd) got = 1'b1;
    end
    e = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: no result after %0d cycles, want found=%0b", name, budget, e.f);
      return;
    end
    total++;
    if ({o_draw, o_nf, o_fnd} !== {e.f, !e.f, 1'b0}) begin
      bad++;
      $display("FAIL %s_outcome: draw/nf/found=%b, want %b", name, {o_draw, o_nf, o_fnd},
               {e.f, !e.f, 1'b0});
    end
    total++;
    if (o_key !== e.k) begin
      bad++;
      $display("FAIL %s_key: got %h, want %h", name, o_key, e.k);
    end
    total++;
    if (o_pt !== e.p) begin
      bad++;
      $display("FAIL %s_pt: got %h, want %h", name, o_pt, e.p);
    end
    if (e.f && o_draw) begin
      repeat (3) @(negedge clk);
      sample(sel);
      total++;
      if ({o_draw, o_fnd, o_sw} !== 3'b100) begin
        bad++;
        $display("FAIL %s_display_hold: draw/found/sw=%b, want 100", name, {o_draw, o_fnd, o_sw});
      end
      set_ddp(sel, 1'b1);
      @(negedge clk);
      set_ddp(sel, 1'b0);
      sample(sel);
      total++;
      if ({o_draw, o_fnd, o_nf} !== 3'b010) begin
        bad++;
        $display("FAIL %s_found: draw/found/nf=%b, want 010", name, {o_draw, o_fnd, o_nf});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_start(0, 1'b1, hw ^ rep(8'h07), 24'd255);
    repeat (3) @(negedge clk);
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    check_zero(2, "reset_c");
    reset = 1'b0;
    set_start(0, 1'b0, '0, '0);
    @(negedge clk);
    check_zero(0, "reset_idle_a");
  endtask

  task automatic test_basic_find();
    launch(0, hw ^ rep(8'h07), 24'd255, '{f: 1'b1, k: 24'd7, p: hw}, "basic");
    collect(0, 200, "basic");
  endtask

  task automatic test_start_ignored_and_restart();
    launch(0, hw ^ rep(8'h07), 24'd255, '{f: 1'b1, k: 24'd7, p: hw}, "ignore");
    repeat (2) @(negedge clk);
    set_start(0, 1'b1, hw ^ rep(8'h01), 24'd255);
    @(negedge clk);
    set_start(0, 1'b0, '0, '0);
    collect(0, 200, "ignore");
    launch(0, hw ^ rep(8'h03), 24'd255, '{f: 1'b1, k: 24'd3, p: hw}, "restart");
    collect(0, 200, "restart");
  endtask

  task automatic test_not_found_masked();
    launch(1, hw ^ rep(8'h03), 24'd2, '{f: 1'b0, k: 24'd0, p: '0}, "masked");
    collect(1, 10, "masked");
  endtask

  task automatic test_lowest_index();
    launch(1, rep(8'h5F), 24'd255, '{f: 1'b1, k: 24'd5, p: rep(8'h5A)}, "lowest");
    collect(1, 200, "lowest");
  endtask

  task automatic test_reset_mid_search();
    exp_t dummy;
    launch(0, hw ^ rep(8'h07), 24'd255, '{f: 1'b1, k: 24'd7, p: hw}, "midrst");
    dummy = exp_q.pop_back();
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero(0, "midrst_zero");
    launch(0, hw ^ rep(8'h01), 24'd255, '{f: 1'b1, k: 24'd1, p: hw}, "fresh");
    collect(0, 200, "fresh");
  endtask

  task automatic test_overflow();
    prev_kd = '0;
    wrapped = 1'b0;
    launch(2, {8{16'h0080}}, 24'h00FFFF, '{f: 1'b0, k: 24'd0, p: '0}, "ovf");
    collect(2, 60000, "ovf");
    total++;
    if (wrapped !== 1'b0) begin
      bad++;
      $display("FAIL ovf_wrap: key_display went backwards=%0b, want 0", wrapped);
    end
    sample(2);
    total++;
    if (o_kd !== 16'hFFF8) begin
      bad++;
      $display("FAIL ovf_last_base: got %h, want fff8", o_kd);
    end
  endtask

  initial begin
    hw = "HELLO WORLD 2021";
    test_reset();
    test_basic_find();
    test_start_ignored_and_restart();
    test_not_found_masked();
    test_lowest_index();
    test_reset_mid_search();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codebreaker_multi.md
CODEBREAKER_MULTI -- requirements
Module: codebreaker_multi

Interface
REQ-001 Parameter NUM_ENG, default 2, meaning parallel decrypt engines; legal values 1, 2, 4, 8.
REQ-002 Parameter KEY_W, default 24, meaning search key width; legal range 16..24.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a search; honoured in IDLE, FOUND and NOT_FOUND only.
REQ-006 cyphertext  input  128  ciphertext, sampled on an accepted start.
REQ-007 key_limit  input  KEY_W  last key to try (inclusive), sampled on an accepted start.
REQ-008 key_display  output  16  base_key[KEY_W-1:KEY_W-16].
REQ-009 stopwatch_run  output  1  high in SEARCH and CHECK.
REQ-010 draw_plaintext  output  1  high in DISPLAY only.
REQ-011 done_drawing_plaintext  input  1  drawer completion, honoured in DISPLAY only.
REQ-012 plaintext_to_draw  output  128  registered winning plaintext.
REQ-013 found  output  1  high in FOUND.
REQ-014 not_found  output  1  high in NOT_FOUND.
REQ-015 found_key  output  KEY_W  registered winning key.

Function
REQ-016 States: IDLE, SEARCH, CHECK, DISPLAY, FOUND, NOT_FOUND.
REQ-017 An accepted start loads base_key=0, latches cyphertext and key_limit, and enters SEARCH on the next cycle.
REQ-018 Engine i receives key base_key+i, zero-extended to 24 bits, and the latched ciphertext.
REQ-019 All engines have enable=1 in SEARCH and enable=0 in every other state; SEARCH exits to CHECK in the cycle after all engines assert done.
REQ-020 CHECK lasts exactly one cycle, so enable drops for one cycle between key batches.
REQ-021 Engine i is a candidate if all 16 output bytes are in A-Z, 0-9 or space, and base_key+i <= key_limit, with the sum computed in KEY_W+1 bits.
REQ-022 In CHECK, if any engine is a candidate, the lowest-index candidate wins:
  - its bytes_out is registered into plaintext_to_draw;
  - base_key+i is registered into found_key;
  - next state is DISPLAY.
REQ-023 In CHECK with no candidate, next = base_key+NUM_ENG, computed in KEY_W+1 bits.
  - If next > key_limit or next overflows KEY_W bits, enter NOT_FOUND.
  - Otherwise load base_key=next and enter SEARCH.
REQ-024 DISPLAY holds until done_drawing_plaintext=1, then enters FOUND.
REQ-025 FOUND and NOT_FOUND hold until reset or an accepted start; an accepted start restarts per REQ-017.
REQ-026 start outside IDLE, FOUND and NOT_FOUND is ignored; no state, register or output changes.
REQ-027 key_limit < NUM_ENG-1 is legal: out-of-range engines are masked per REQ-021.

Reset
REQ-028 Reset takes priority over all inputs, including start.
REQ-029 Reset mid-search also resets every engine.
REQ-030 Reset values:
  - state=IDLE;
  - base_key, found_key, plaintext_to_draw, latched ciphertext and latched key_limit = 0;
  - all 1-bit outputs = 0.

Structure
REQ-031 Package codebreaker_pkg holds:
  - the state enum typedef;
  - constants for the ASCII bounds "A", "Z", "0", "9" and space;
  - a per-byte printable-check function.
REQ-032 Sub-module ascii_check16 (128-bit input, 1-bit pass output, combinational) is instantiated once per engine.
REQ-033 Engines are existing decrypt_rc4 instances, NUM_ENG copies, created in a generate loop.
REQ-034 The winner select is a parametrised priority encoder and contains no per-NUM_ENG hand-written logic.

Verification
REQ-035 The bench uses a decrypt_rc4 stub:
  - done asserts 4 enabled cycles after enable rises;
  - bytes_out = bytes_in XOR {16{key[7:0]}}.
REQ-036 NUM_ENG=2, ciphertext="HELLO WORLD 2021" XOR {16{8'h07}}, key_limit=255, start pulse -> found_key=7, plaintext_to_draw="HELLO WORLD 2021", DISPLAY then FOUND after done_drawing_plaintext.
REQ-037 NUM_ENG=4, ciphertext valid for keys 5 and 6 -> found_key=5 (lowest index wins within the batch base 4).
REQ-038 NUM_ENG=4, key_limit=2, correct key 3 -> NOT_FOUND after one CHECK; found=0; plaintext_to_draw=0.
REQ-039 KEY_W=16, key_limit=16'hFFFF, no valid key -> NOT_FOUND when base_key+NUM_ENG overflows; base_key never wraps to 0.
REQ-040 Reset asserted during SEARCH -> state=IDLE and all outputs=0 the next cycle; a fresh start then searches from key 0.
REQ-041 start during SEARCH is ignored; start in FOUND launches a new search with new ciphertext and clears found the next cycle.
